// File: rtl/compressed_stream_packer_if.sv
// Group/beat handshake bundle between the compressor,
// the stream packer and the downstream consumer.
interface compressed_stream_packer_if;
  logic         inValid;
  logic         inReady;
  logic [255:0] dataIn;
  logic [15:0]  tagIn;
  logic         flushIn;
  logic         outValid;
  logic         outReady;
  logic [255:0] dataOut;
  logic [5:0]   outBytes;
  logic         outLast;
  logic         flushDone;

  modport master (
    output inValid, dataIn, tagIn, flushIn, outReady,
    input  inReady, outValid, dataOut, outBytes,
    input  outLast, flushDone
  );

  modport slave (
    input  inValid, dataIn, tagIn, flushIn, outReady,
    output inReady, outValid, dataOut, outBytes,
    output outLast, flushDone
  );
endinterface

// File: rtl/compressed_stream_packer.sv
// Packs tagged 8-word groups into byte-aligned records and
// streams them out as 256-bit beats, with a draining flush.
module compressed_stream_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 8,
  parameter int TAG_WIDTH  = 2,
  parameter int OUT_BYTES  = 32,
  parameter int BUF_BYTES  = 96
) (
  input logic clk,
  input logic reset,
  compressed_stream_packer_if.slave bus
);
  localparam int REC_MAX = 2 + NUM_DATA * DATA_WIDTH / 8;
  localparam int REC_W   = REC_MAX * 8;
  localparam int BUF_W   = BUF_BYTES * 8;
  localparam int OUT_W   = OUT_BYTES * 8;
  localparam logic [6:0] BEAT = 7'(OUT_BYTES);
  localparam logic [6:0] READY_MAX = 7'(BUF_BYTES - REC_MAX);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LAST
  } state_t;

  state_t state_q, state_d;
  logic [6:0] count_q, count_d;
  logic [6:0] base;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [REC_W-1:0] rec;
  logic [5:0] rec_len;
  logic [5:0] off;
  logic [5:0] keep;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] kept;
  logic accept;
  logic transfer;

  // Compact the record: tag header, then each word's kept low bytes.
  always_comb begin
    rec  = '0;
    off  = 6'd2;
    keep = '0;
    word = '0;
    kept = '0;
    rec[15:0] = bus.tagIn;
    for (int i = 0; i < NUM_DATA; i++) begin
      word = bus.dataIn[i*DATA_WIDTH +: DATA_WIDTH];
      unique case (bus.tagIn[i*TAG_WIDTH +: TAG_WIDTH])
        2'b00: begin
          kept = '0;
          keep = 6'd0;
        end
        2'b01: begin
          kept = DATA_WIDTH'(word[7:0]);
          keep = 6'd1;
        end
        2'b10: begin
          kept = DATA_WIDTH'(word[15:0]);
          keep = 6'd2;
        end
        default: begin
          kept = word;
          keep = 6'd4;
        end
      endcase
      rec = rec | ({{(REC_W-DATA_WIDTH){1'b0}}, kept}
                   << {off, 3'b000});
      off = off + keep;
    end
    rec_len = off;
  end

  assign bus.inReady = (state_q == RUN) &&
                       (count_q <= READY_MAX);
  assign accept   = bus.inValid && bus.inReady;
  assign transfer = bus.outValid && bus.outReady;
  assign bus.dataOut = buf_q[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.flushIn) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_q == 7'd0) state_d = RUN;
        else if (count_q < BEAT) state_d = LAST;
        else if (count_q == BEAT && transfer) state_d = RUN;
      end
      LAST: begin
        if (transfer) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    bus.outValid  = 1'b0;
    bus.outLast   = 1'b0;
    bus.flushDone = 1'b0;
    bus.outBytes  = '0;
    unique case (state_q)
      RUN: begin
        bus.outValid = count_q >= BEAT;
      end
      DRAIN: begin
        bus.outValid  = count_q >= BEAT;
        bus.outLast   = count_q == BEAT;
        bus.flushDone = (count_q == 7'd0) ||
                        (count_q == BEAT && bus.outReady);
      end
      LAST: begin
        bus.outValid  = 1'b1;
        bus.outLast   = 1'b1;
        bus.flushDone = bus.outReady;
      end
      default: ;
    endcase
    if (bus.outValid)
      bus.outBytes = (state_q == LAST) ? count_q[5:0]
                                       : 6'(OUT_BYTES);
  end

  // Bytes at and above count stay zero, so records can be OR-merged.
  always_comb begin
    base  = count_q;
    buf_d = buf_q;
    if (transfer) begin
      buf_d = buf_q >> OUT_W;
      base  = (state_q == LAST) ? 7'd0 : count_q - BEAT;
    end
    count_d = base;
    if (accept) begin
      buf_d = buf_d |
              ({{(BUF_W-REC_W){1'b0}}, rec} << {base, 3'b000});
      count_d = base + 7'(rec_len);
    end
  end
endmodule

// File: tb/tb_compressed_stream_packer.sv
// Randomised bench for compressed_stream_packer against a
// byte-stream reference model of the record format.
module tb_compressed_stream_packer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  compressed_stream_packer_if bus();

  compressed_stream_packer dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  logic [255:0] beat_d[$];
  int beat_n[$];
  bit beat_l[$];

  int bytes_in, bytes_out, occ, max_occ, cyc;
  int ready_bad, valid_bad, stall_bad;
  int zero_bad, last_bad, bytes_bad;
  int n_acc, n_both, n_done, done_cyc;
  bit model_run, last_acc, last_done, done_xfer, held;
  logic [255:0] held_d;
  logic [5:0] held_n;
  logic held_l;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int stream_diff();
    int d;
    if (got_q.size() > exp_q.size())
      d = got_q.size() - exp_q.size();
    else
      d = exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) d++;
    return d;
  endfunction

  function automatic int health();
    return ready_bad + valid_bad + stall_bad +
           zero_bad + last_bad + bytes_bad;
  endfunction

  task automatic push_record(input logic [255:0] d,
                             input logic [15:0] t);
    int n;
    n = 2;
    exp_q.push_back(t[7:0]);
    exp_q.push_back(t[15:8]);
    for (int i = 0; i < 8; i++) begin
      int k;
      case (t[2*i +: 2])
        2'd0: k = 0;
        2'd1: k = 1;
        2'd2: k = 2;
        default: k = 4;
      endcase
      for (int b = 0; b < k; b++)
        exp_q.push_back(d[32*i + 8*b +: 8]);
      n += k;
    end
    bytes_in += n;
  endtask

  task automatic model_clear();
    exp_q.delete();
    got_q.delete();
    beat_d.delete();
    beat_n.delete();
    beat_l.delete();
    bytes_in = 0; bytes_out = 0; max_occ = 0;
    ready_bad = 0; valid_bad = 0; stall_bad = 0;
    zero_bad = 0; last_bad = 0; bytes_bad = 0;
    n_acc = 0; n_both = 0; n_done = 0; done_cyc = -1;
    held = 0; done_xfer = 0;
  endtask

  task automatic tick();
    bit acc, xfer;
    @(negedge clk);
    cyc++;
    occ = bytes_in - bytes_out;
    if (occ > max_occ) max_occ = occ;
    acc  = bus.inValid && bus.inReady;
    xfer = bus.outValid && bus.outReady;
    if (model_run) begin
      if (bus.inReady !== (occ <= 62)) ready_bad++;
      if (bus.outValid !== (occ >= 32)) valid_bad++;
    end
    if (held && (bus.outValid !== 1'b1 ||
                 bus.dataOut !== held_d ||
                 bus.outBytes !== held_n ||
                 bus.outLast !== held_l))
      stall_bad++;
    held   = bus.outValid && !bus.outReady;
    held_d = bus.dataOut;
    held_n = bus.outBytes;
    held_l = bus.outLast;
    if (acc) begin
      push_record(bus.dataIn, bus.tagIn);
      n_acc++;
    end
    if (xfer) begin
      int n;
      n = int'(bus.outBytes);
      if (n != ((occ >= 32) ? 32 : occ)) bytes_bad++;
      if (bus.outLast !== bus.flushDone) last_bad++;
      for (int k = 0; k < 32; k++)
        if (k < n) got_q.push_back(bus.dataOut[8*k +: 8]);
        else if (bus.dataOut[8*k +: 8] !== 8'h00) zero_bad++;
      bytes_out += n;
      beat_d.push_back(bus.dataOut);
      beat_n.push_back(n);
      beat_l.push_back(bus.outLast);
    end
    if (acc && xfer) n_both++;
    last_acc  = acc;
    last_done = bus.flushDone;
    if (bus.flushDone) begin
      n_done++;
      done_cyc = cyc;
      done_xfer = xfer;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(input logic [255:0] d,
                            input logic [15:0] t);
    int w;
    w = 0;
    bus.inValid = 1'b1;
    bus.dataIn = d;
    bus.tagIn = t;
    do begin
      tick();
      w++;
    end while (!last_acc && w < 200);
    bus.inValid = 1'b0;
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL send_group: accepted=0 required=1");
    end
  endtask

  task automatic do_flush();
    int w;
    w = 0;
    bus.flushIn = 1'b1;
    tick();
    bus.flushIn = 1'b0;
    bus.inValid = 1'b0;
    model_run = 0;
    do begin
      tick();
      w++;
    end while (!last_done && w < 60);
    model_run = 1;
    checks++;
    if (!last_done) begin
      errors++;
      $display("FAIL flush_done timeout: seen=0 required=1");
    end
  endtask

  task automatic test_reset();
    model_clear();
    model_run = 1;
    bus.outReady = 1'b0;
    send_group(rand256(), 16'hFFFF);
    send_group(rand256(), 16'h0003);
    tick();
    tick();
    checks++;
    if (bus.outValid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prestall outValid=%b required=1",
               bus.outValid);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outValid got=%b required=0",
               bus.outValid);
    end
    checks++;
    if (bus.dataOut !== 256'h0) begin
      errors++;
      $display("FAIL reset_dataOut got=%h required=0",
               bus.dataOut);
    end
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inReady got=%b required=1",
               bus.inReady);
    end
    checks++;
    if ({bus.outBytes, bus.outLast, bus.flushDone} !== 8'h0) begin
      errors++;
      $display("FAIL reset_misc bytes=%0d last=%b done=%b required=0",
               bus.outBytes, bus.outLast, bus.flushDone);
    end
    @(posedge clk);
    #1;
    model_clear();
    bus.outReady = 1'b1;
    repeat (6) tick();
    checks++;
    if (beat_n.size() != 0) begin
      errors++;
      $display("FAIL reset_stale beats=%0d required=0",
               beat_n.size());
    end
    checks++;
    if (health() != 0) begin
      errors++;
      $display("FAIL reset_health bad=%0d required=0", health());
    end
  endtask

  task automatic test_zero_tag();
    model_clear();
    bus.outReady = 1'b1;
    send_group(rand256(), 16'h0000);
    do_flush();
    checks++;
    if (beat_n.size() != 1) begin
      errors++;
      $display("FAIL zero_tag_beats got=%0d required=1",
               beat_n.size());
    end else begin
      checks++;
      if (beat_n[0] != 2 || beat_l[0] != 1'b1 ||
          beat_d[0] !== 256'h0) begin
        errors++;
        $display("FAIL zero_tag_beat bytes=%0d last=%b data=%h required=2/1/0",
                 beat_n[0], beat_l[0], beat_d[0]);
      end
    end
    checks++;
    if (n_done != 1 || !done_xfer) begin
      errors++;
      $display("FAIL zero_tag_done pulses=%0d on_xfer=%b required=1/1",
               n_done, done_xfer);
    end
  endtask

  task automatic test_full_tag();
    logic [255:0] d, b0;
    model_clear();
    bus.outReady = 1'b1;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = i + 1;
    send_group(d, 16'hFFFF);
    do_flush();
    checks++;
    if (beat_n.size() != 2) begin
      errors++;
      $display("FAIL full_tag_beats got=%0d required=2",
               beat_n.size());
    end else begin
      b0 = beat_d[0];
      checks++;
      if (beat_n[0] != 32 || beat_l[0] != 1'b0 ||
          b0[47:0] !== 48'h0000_0001_FFFF ||
          b0[255:240] !== 16'h0008) begin
        errors++;
        $display("FAIL full_tag_beat0 bytes=%0d last=%b lo=%h hi=%h required=32/0/000000 01ffff/0008",
                 beat_n[0], beat_l[0], b0[47:0], b0[255:240]);
      end
      checks++;
      if (beat_n[1] != 2 || beat_l[1] != 1'b1 ||
          beat_d[1] !== 256'h0) begin
        errors++;
        $display("FAIL full_tag_beat1 bytes=%0d last=%b data=%h required=2/1/0",
                 beat_n[1], beat_l[1], beat_d[1]);
      end
    end
    checks++;
    if (stream_diff() != 0) begin
      errors++;
      $display("FAIL full_tag_stream diff=%0d required=0",
               stream_diff());
    end
  endtask

  task automatic test_backpressure();
    model_clear();
    bus.outReady = 1'b0;
    bus.inValid = 1'b1;
    bus.tagIn = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      bus.dataIn = rand256();
      tick();
    end
    checks++;
    if (n_acc != 2) begin
      errors++;
      $display("FAIL bp_accepts got=%0d required=2", n_acc);
    end
    checks++;
    if (bus.inReady !== 1'b0 || bus.outValid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall inReady=%b outValid=%b required=0/1",
               bus.inReady, bus.outValid);
    end
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    do_flush();
    checks++;
    if (beat_n.size() != 3) begin
      errors++;
      $display("FAIL bp_beats got=%0d required=3", beat_n.size());
    end else begin
      checks++;
      if (beat_n[2] != 4) begin
        errors++;
        $display("FAIL bp_tail bytes=%0d required=4", beat_n[2]);
      end
    end
    checks++;
    if (stream_diff() != 0 || health() != 0) begin
      errors++;
      $display("FAIL bp_stream diff=%0d bad=%0d required=0/0",
               stream_diff(), health());
    end
  endtask

  task automatic test_stream_5555();
    model_clear();
    bus.outReady = 1'b1;
    bus.inValid = 1'b1;
    bus.tagIn = 16'h5555;
    for (int i = 0; i < 40; i++) begin
      bus.dataIn = rand256();
      tick();
    end
    bus.inValid = 1'b0;
    do_flush();
    checks++;
    if (n_acc != 40) begin
      errors++;
      $display("FAIL s5555_accepts got=%0d required=40", n_acc);
    end
    checks++;
    if (n_both == 0) begin
      errors++;
      $display("FAIL s5555_overlap got=0 required=nonzero");
    end
    checks++;
    if (max_occ > 41) begin
      errors++;
      $display("FAIL s5555_occupancy got=%0d required<=41", max_occ);
    end
    checks++;
    if (stream_diff() != 0 || health() != 0) begin
      errors++;
      $display("FAIL s5555_stream diff=%0d bad=%0d required=0/0",
               stream_diff(), health());
    end
  endtask

  task automatic test_flush_empty();
    int c0;
    model_clear();
    bus.outReady = 1'b1;
    bus.inValid = 1'b0;
    bus.flushIn = 1'b1;
    tick();
    c0 = cyc;
    bus.flushIn = 1'b0;
    model_run = 0;
    repeat (5) tick();
    model_run = 1;
    checks++;
    if (n_done != 1 || done_cyc != c0 + 1) begin
      errors++;
      $display("FAIL flush_empty_done pulses=%0d at=%0d required=1/%0d",
               n_done, done_cyc, c0 + 1);
    end
    checks++;
    if (beat_n.size() != 0) begin
      errors++;
      $display("FAIL flush_empty_beats got=%0d required=0",
               beat_n.size());
    end
  endtask

  task automatic test_flush_with_accept();
    int a0;
    model_clear();
    bus.outReady = 1'b1;
    send_group(rand256(), 16'($urandom));
    send_group(rand256(), 16'($urandom));
    a0 = n_acc;
    bus.inValid = 1'b1;
    bus.dataIn = rand256();
    bus.tagIn = 16'($urandom) | 16'hC000;
    do_flush();
    checks++;
    if (n_acc != a0 + 1) begin
      errors++;
      $display("FAIL flush_acc_accepts got=%0d required=%0d",
               n_acc, a0 + 1);
    end
    checks++;
    if (stream_diff() != 0 || health() != 0) begin
      errors++;
      $display("FAIL flush_acc_stream diff=%0d bad=%0d required=0/0",
               stream_diff(), health());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      model_clear();
      for (int i = 0; i < 150; i++) begin
        bus.inValid = 1'($urandom_range(0, 1));
        bus.dataIn = rand256();
        bus.tagIn = 16'($urandom);
        bus.outReady = ($urandom_range(0, 9) < 7);
        tick();
      end
      bus.inValid = 1'b0;
      bus.outReady = 1'b1;
      do_flush();
      checks++;
      if (stream_diff() != 0 || health() != 0) begin
        errors++;
        $display("FAIL random_round%0d diff=%0d bad=%0d required=0/0",
                 r, stream_diff(), health());
      end
      checks++;
      if (n_done != 1) begin
        errors++;
        $display("FAIL random_done%0d pulses=%0d required=1",
                 r, n_done);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.inValid = 1'b0;
    bus.dataIn = '0;
    bus.tagIn = '0;
    bus.flushIn = 1'b0;
    bus.outReady = 1'b0;
    cyc = 0;
    model_run = 1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_zero_tag();
    test_full_tag();
    test_backpressure();
    test_stream_5555();
    test_flush_empty();
    test_flush_with_accept();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/compressed_stream_packer.md
Name: compressed_stream_packer

Overview:
- Sits directly downstream of the eight-word compressor.
- Each accepted group is 8 compressed words plus 8 two-bit size tags. The block serialises it as a byte-aligned record: a 16-bit tag header followed by only the significant bytes of each word.
- Records are packed back-to-back into 256-bit output beats with a valid/ready handshake.
- A flush sequence drains the packer and emits a final zero-padded beat with a valid-byte count.

Parameters:
- DATA_WIDTH, 32, bits per input word (fixed at 32; tag encoding assumes it).
- NUM_DATA, 8, words per input group.
- TAG_WIDTH, 2, bits per word tag.
- OUT_BYTES, 32, bytes per output beat.
- BUF_BYTES, 96, packing buffer capacity in bytes.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  input group valid.
- inReady  out  1  packer can accept a group this cycle.
- dataIn  in  256  compressed words; word i is dataIn[32i+31:32i].
- tagIn  in  16  tag i is tagIn[2i+1:2i].
- flushIn  in  1  request to drain; a one-cycle pulse is sufficient.
- outValid  out  1  output beat valid.
- outReady  in  1  downstream accepts the beat.
- dataOut  out  256  packed beat; byte k is dataOut[8k+7:8k].
- outBytes  out  6  valid bytes in the beat (1..32).
- outLast  out  1  final beat of a flush.
- flushDone  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Tag to bytes kept per word:
  - 00 = 0 bytes
  - 01 = 1 byte (word[7:0])
  - 10 = 2 bytes (word[15:0])
  - 11 = 4 bytes (full word)
- Record layout:
  - bytes 0-1 = tagIn[15:0], little-endian.
  - then words 0..7 in order, each contributing its kept low bytes little-endian.
  - recLen = 2 + sum of kept bytes; range 2..34.
- Buffer:
  - byte array with occupancy count (0..96).
  - an accepted record is written at byte offsets count..count+recLen-1.
  - the output beat is buffer bytes 0..31; on a handshake the buffer shifts down 32 bytes.
- Handshakes:
  - accept = inValid & inReady.
  - beat transfer = outValid & outReady.
- inReady = (state==RUN) & (count <= 62), registered from the current count. It is not combinationally dependent on inValid or outReady.
- Latency: an accepted record's bytes are visible in the buffer the next cycle.
  - outValid in RUN = (count >= 32), with outBytes=32 and outLast=0.
- Simultaneous accept and transfer in one cycle: count_next = count + recLen - 32. The new record is written at offset count-32 after the shift. This is the only allowed case of write and shift together.
- While outValid=1 and outReady=0, dataOut, outBytes and outLast hold stable.
- Flush FSM states and transitions:
  - RUN: if flushIn is sampled high, go to DRAIN. An accept in that same cycle still completes.
  - DRAIN:
    - inReady=0.
    - While count >= 32, emit full beats.
    - outLast=1 on a full beat that leaves count=0.
    - If count==0 after a transfer, pulse flushDone and go to RUN.
    - If count==0 on entry (nothing to drain), pulse flushDone next cycle and go to RUN; no beat is emitted.
    - If 0 < count < 32, go to LAST.
  - LAST:
    - outValid=1, outBytes=count, outLast=1.
    - Bytes count..31 of dataOut are zero.
    - On transfer: count=0, pulse flushDone, go to RUN.
- flushIn outside RUN is ignored.
- Reset, including mid-flush or mid-stall:
  - state=RUN, count=0, buffer zeroed.
  - outValid=0, outLast=0, flushDone=0, dataOut=0, outBytes=0.
  - inReady=1 in the first cycle after reset deasserts.
- Overflow is impossible by construction: 62+34=96.

Test Plan:
- Reset held 3 cycles during backpressure with count=40 -> after release: outValid=0, dataOut=0, inReady=1, count=0; no stale beat ever appears.
- One group, tagIn=16'h0000, then flushIn -> single beat: outBytes=2, outLast=1, dataOut=0, flushDone pulses on the transfer cycle.
- One group, tagIn=16'hFFFF, dataIn word i = i+1:
  - first beat outBytes=32, with bytes 0-1=FF FF and bytes 2-5=01 00 00 00.
  - bytes 30-31=08 00.
  - flush -> second beat outBytes=2, bytes 0-1=00 00, outLast=1.
- Backpressure: outReady=0 with continuous tagIn=16'hFFFF groups -> exactly 2 groups accepted (count=68), inReady=0 thereafter. After outReady=1, the beats equal the byte-exact concatenation of the records.
- Continuous tagIn=16'h5555 groups (recLen=10) with outReady=1 -> simultaneous accept and transfer cycles occur, count stays <= 41, and there is no byte loss or duplication versus a reference model.
- flushIn asserted with count=0 -> no beat, flushDone one cycle later. flushIn asserted in the same cycle as an accept -> that record is included in the drained output.
